// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous imem request, output stage with redirect/squash/stall.
// Optional performance counters are built only when INSTR_FETCH_PERF_EN is defined.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        req_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        taken;
  logic [31:0] target;

  // Jump wins over branch; branch offset is the sign-extended word offset.
  function automatic logic [31:0] redirect_target(
    input logic        is_jump,
    input logic [31:0] link,
    input logic [31:0] word
  );
    logic signed [31:0] offset;
    offset = {{14{word[15]}}, word[15:0], 2'b00};
    if (is_jump)
      return {link[31:28], word[25:0], 2'b00};
    else
      return link + offset;
  endfunction

  assign imem_addr   = stall ? req_pc : pc_q;
  assign instr       = d_instr;
  assign opcode      = d_instr[31:26];
  assign pc          = d_pc;
  assign pc_plus4    = d_pc + 32'd4;
  assign instr_valid = d_valid;

  assign taken  = d_valid & ~stall & (jump | (branch & alu_zero));
  assign target = redirect_target(jump, pc_plus4, d_instr);

  // Request stage (pc_q -> req_pc) and output stage (imem_rdata -> d_instr)
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      req_pc    <= RESET_PC;
      req_valid <= 1'b0;
      d_instr   <= 32'd0;
      d_pc      <= RESET_PC;
      d_valid   <= 1'b0;
    end else if (!stall) begin
      d_instr <= imem_rdata;
      d_pc    <= req_pc;
      req_pc  <= pc_q;
      if (taken) begin
        pc_q      <= target;
        req_valid <= 1'b0;
        d_valid   <= 1'b0;
      end else begin
        pc_q      <= pc_q + 32'd4;
        req_valid <= 1'b1;
        d_valid   <= req_valid;
      end
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q  <= 32'd0;
      instr_q  <= 32'd0;
      bubble_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (!stall) begin
        if (d_valid)
          instr_q <= instr_q + 32'd1;
        else
          bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;
  assign bubble_count = bubble_q;
`else
  assign cycle_count  = 32'd0;
  assign instr_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle MIPS core. It sits directly upstream of the main controller. It holds the program counter and drives the synchronous instruction memory. It presents one decoded-ready instruction per cycle (`opcode` feeds the controller) and redirects on the controller's `jump`/`branch` outputs, with squash, stall and link-address support.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address loaded into the PC on reset.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets the block.
- `stall`  in  1  freeze fetch and decode registers this cycle.
- `jump`  in  1  from controller; unconditional redirect for current instruction.
- `branch`  in  1  from controller; conditional redirect for current instruction.
- `alu_zero`  in  1  ALU zero flag for the current instruction.
- `imem_addr`  out  32  byte address to instruction memory (memory returns data 1 cycle later).
- `imem_rdata`  in  32  instruction word for address presented previous cycle.
- `instr`  out  32  current instruction.
- `opcode`  out  6  `instr[31:26]`, to controller.
- `instr_valid`  out  1  `instr` is a real instruction (0 = bubble).
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, link value for jal.
- `cycle_count`, `instr_count`, `bubble_count`  out  32 each  performance counters (see Configuration).

## Operation
- State: `pc_q` (next fetch address), `req_pc`/`req_valid` (in-flight read), `d_instr`/`d_pc`/`d_valid` (output stage).
- `imem_addr = stall ? req_pc : pc_q`. During a stall the in-flight address is re-read, so `imem_rdata` on the following cycle still matches `req_pc`.
- Normal cycle (`stall==0`, no redirect):
  - `d_instr<=imem_rdata`, `d_pc<=req_pc`, `d_valid<=req_valid`.
  - `req_pc<=pc_q`, `req_valid<=1`.
  - `pc_q<=pc_q+4`.
- Redirect: `taken = d_valid & ~stall & (jump | (branch & alu_zero))`.
  - Jump target `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - Branch target `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Jump wins if both are asserted.
- On `taken`:
  - `pc_q<=target`, `req_valid<=0`, `d_valid<=0`. Both younger fetches are squashed.
- `stall==1`: every register holds. `jump`/`branch` are ignored and take effect on the first cycle with `stall==0` while the instruction is still in the output stage.
- `jump`/`branch` are ignored while `instr_valid==0`.
- Arithmetic: all PC math is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to 0. Bits [1:0] of the PC are not checked.
- Combinational outputs: `opcode=d_instr[31:26]`, `instr=d_instr`, `pc=d_pc`, `pc_plus4=d_pc+4`, `instr_valid=d_valid`.

## Timing
- Reset (`reset==0` at edge), overriding stall/redirect:
  - `pc_q<=RESET_PC`, `req_pc<=RESET_PC`, `req_valid<=0`.
  - `d_instr<=0`, `d_pc<=RESET_PC`, `d_valid<=0`, counters `<=0`.
  - `imem_addr==RESET_PC` in the first cycle after reset.
- Startup: with cycle 0 as the first cycle with reset deasserted, `instr_valid` is 0 in cycles 0–1. Cycle 2 shows `mem[RESET_PC]`. Throughput is 1 instruction per cycle thereafter.
- Fetch-to-output latency is 2 cycles.
- Redirect penalty: `taken` in cycle t gives bubbles in t+1 and t+2; the target instruction is valid in t+3.
- Not-taken branch: 0 penalty.
- Stall of N cycles adds exactly N cycles. No instruction is skipped or duplicated.
- Reset mid-operation discards all in-flight state within one edge.

## Configuration
- `INSTR_FETCH_PERF_EN` defined:
  - `cycle_count` increments every non-reset cycle.
  - `instr_count` increments on each cycle with `instr_valid & ~stall`.
  - `bubble_count` increments on each cycle with `~instr_valid & ~stall`.
  - All counters wrap at 2^32 and clear on reset.
- Not defined: the three counters are constant 0 and no counter registers are built.

## Test plan
- Reset release, `mem[i]=32'h2000_0000|i` at `RESET_PC=0` -> `instr_valid` 0,0 then `pc`=0,4,8,… each cycle with matching `instr`; `imem_addr` first = 0.
- `j` at pc 0x08 with field 0x10 -> bubbles for 2 cycles, then `pc`=0x40, `pc_plus4`=0x44.
- `beq` at 0x10, imm=16'hFFFE: with `alu_zero=1` -> 2 bubbles then `pc`=0x0C; with `alu_zero=0` -> `pc`=0x14 next cycle, no bubble.
- `stall` high 3 cycles while `pc`=0x0C -> `instr`/`pc` held 4 cycles total, then 0x10, 0x14 with nothing skipped or repeated.
- `stall` high with `jump=1` -> no redirect during stall; redirect occurs on release cycle, 2 bubbles follow.
- `reset` driven 0 mid-stream -> next cycle `instr_valid`=0, `imem_addr`=`RESET_PC`; with `INSTR_FETCH_PERF_EN` all counters read 0, else always 0.
